// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: mode select values and
// direction codes.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT    = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_MIRROR   = 2'd2,
        MODE_FLASH    = 2'd3
    } mode_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/led_pattern_decode.sv
// Combinational pattern generator: turns (mode, idx, phase) into the LED image.
// In MIRROR, idx 0 is the all-off state and idx k+1 lights pair k.
module led_pattern_decode
    import led_seq_pkg::*;
#(
    parameter int NB_LEDS = 4,
    parameter int IDX_W   = $clog2(NB_LEDS + 1)
) (
    input  logic [1:0]         mode,
    input  logic [IDX_W-1:0]   idx,
    input  logic               phase,
    output logic [NB_LEDS-1:0] pattern
);

    logic [IDX_W-1:0] pair;

    always_comb begin
        pattern = '0;
        pair    = idx - IDX_W'(1);
        case (mode)
            MODE_SHIFT, MODE_PINGPONG: begin
                for (int i = 0; i < NB_LEDS; i++)
                    if (idx == IDX_W'(i)) pattern[i] = 1'b1;
            end
            MODE_MIRROR: begin
                if (idx != '0)
                    for (int i = 0; i < NB_LEDS; i++)
                        if (pair == IDX_W'(i) || pair == IDX_W'(NB_LEDS - 1 - i))
                            pattern[i] = 1'b1;
            end
            default: pattern = {NB_LEDS{phase}};
        endcase
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: step FSM over mode/direction/index, with registered
// LED, direction, mode and cycle-complete outputs.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int NB_LEDS = 4,
    parameter int NB_MODE = 2
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_reverse,
    input  logic [NB_MODE-1:0] i_mode,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_dir,
    output logic [NB_MODE-1:0] o_mode,
    output logic               o_wrap
);

    localparam int IW = $clog2(NB_LEDS + 1);
    localparam logic [IW-1:0] LAST = IW'(NB_LEDS - 1);
    localparam logic [IW-1:0] PEN  = IW'(NB_LEDS - 2);
    localparam logic [IW-1:0] KMAX = IW'((NB_LEDS + 1) / 2);
    localparam logic [IW-1:0] ONE  = IW'(1);

    mode_e              mode_q, mode_d;
    logic               dir_q, dir_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               phase_q, phase_d;
    logic               load_pend_q, load_pend_d;
    logic               wrap_d;
    logic [NB_LEDS-1:0] pattern;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            mode_q      <= MODE_SHIFT;
            dir_q       <= DIR_FWD;
            idx_q       <= '0;
            phase_q     <= 1'b0;
            load_pend_q <= 1'b1;
            o_led       <= '0;
            o_wrap      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            load_pend_q <= load_pend_d;
            o_wrap      <= wrap_d;
            if (i_valid) o_led <= pattern;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        dir_d       = dir_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        load_pend_d = load_pend_q;
        wrap_d      = 1'b0;
        if (i_valid) begin
            if (load_pend_q || mode_e'(i_mode) != mode_q) begin
                // Load: reseed in the requested mode without advancing.
                mode_d      = mode_e'(i_mode);
                dir_d       = DIR_FWD;
                idx_d       = '0;
                phase_d     = 1'b0;
                load_pend_d = 1'b0;
            end else begin
                if (i_reverse) dir_d = ~dir_q;
                case (mode_q)
                    MODE_SHIFT: begin
                        if (dir_q == DIR_FWD) begin
                            wrap_d = (idx_q == LAST);
                            idx_d  = wrap_d ? '0 : idx_q + ONE;
                        end else begin
                            wrap_d = (idx_q == '0);
                            idx_d  = wrap_d ? LAST : idx_q - ONE;
                        end
                    end
                    MODE_PINGPONG: begin
                        // Endpoint bounce forces direction, overriding i_reverse.
                        if (dir_q == DIR_FWD) begin
                            if (idx_q == LAST) begin
                                idx_d  = PEN;
                                dir_d  = DIR_REV;
                                wrap_d = 1'b1;
                            end else begin
                                idx_d = idx_q + ONE;
                            end
                        end else begin
                            if (idx_q == '0) begin
                                idx_d  = ONE;
                                dir_d  = DIR_FWD;
                                wrap_d = 1'b1;
                            end else begin
                                idx_d = idx_q - ONE;
                            end
                        end
                    end
                    MODE_MIRROR: begin
                        if (dir_q == DIR_FWD) begin
                            wrap_d = (idx_q == KMAX);
                            idx_d  = wrap_d ? '0 : idx_q + ONE;
                        end else begin
                            wrap_d = (idx_q == ONE);
                            idx_d  = (idx_q == '0) ? KMAX : idx_q - ONE;
                        end
                    end
                    default: begin
                        wrap_d  = phase_q;
                        phase_d = ~phase_q;
                    end
                endcase
            end
        end
    end

    led_pattern_decode #(
        .NB_LEDS (NB_LEDS),
        .IDX_W   (IW)
    ) u_decode (
        .mode    (mode_d),
        .idx     (idx_d),
        .phase   (phase_d),
        .pattern (pattern)
    );

    assign o_dir  = dir_q;
    assign o_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with NB_LEDS=4: every mode, direction
// reversal, endpoint bounces, idle/mode-switch behaviour and async reset.
module tb_led_pattern_seq;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic       i_reverse;
    logic [1:0] i_mode;
    logic [3:0] o_led;
    logic       o_dir;
    logic [1:0] o_mode;
    logic       o_wrap;

    int checks = 0;
    int errors = 0;

    led_pattern_seq #(.NB_LEDS(4), .NB_MODE(2)) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_reverse (i_reverse),
        .i_mode    (i_mode),
        .o_led     (o_led),
        .o_dir     (o_dir),
        .o_mode    (o_mode),
        .o_wrap    (o_wrap)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_led, input logic e_wrap,
                             input logic e_dir, input logic [1:0] e_mode);
        check({tag, ".led"},  {4'h0, o_led},  {4'h0, e_led});
        check({tag, ".wrap"}, {7'h0, o_wrap}, {7'h0, e_wrap});
        check({tag, ".dir"},  {7'h0, o_dir},  {7'h0, e_dir});
        check({tag, ".mode"}, {6'h0, o_mode}, {6'h0, e_mode});
    endtask

    // One valid cycle, sampled 1 time unit after the edge.
    task automatic step(input string tag, input logic rev, input logic [1:0] m,
                        input logic [3:0] e_led, input logic e_wrap,
                        input logic e_dir, input logic [1:0] e_mode);
        i_valid   = 1'b1;
        i_reverse = rev;
        i_mode    = m;
        @(posedge clock);
        #1;
        i_valid   = 1'b0;
        i_reverse = 1'b0;
        check_all(tag, e_led, e_wrap, e_dir, e_mode);
    endtask

    initial begin
        i_reset   = 1'b1;
        i_valid   = 1'b0;
        i_reverse = 1'b0;
        i_mode    = 2'd0;
        #12;
        check_all("reset", 4'b0000, 1'b0, 1'b0, 2'd0);
        @(negedge clock);
        i_reset = 1'b0;

        // SHIFT rotate forward; first valid is the load
        step("sh1", 0, 0, 4'b0001, 0, 0, 0);
        step("sh2", 0, 0, 4'b0010, 0, 0, 0);
        step("sh3", 0, 0, 4'b0100, 0, 0, 0);
        step("sh4", 0, 0, 4'b1000, 0, 0, 0);
        step("sh5", 0, 0, 4'b0001, 1, 0, 0);
        step("sh6", 0, 0, 4'b0010, 0, 0, 0);
        step("sh7", 0, 0, 4'b0100, 0, 0, 0);
        // SHIFT reverse: toggle applies to the following step
        step("shr1", 1, 0, 4'b1000, 0, 1, 0);
        step("shr2", 0, 0, 4'b0100, 0, 1, 0);
        step("shr3", 0, 0, 4'b0010, 0, 1, 0);
        step("shr4", 0, 0, 4'b0001, 0, 1, 0);
        step("shr5", 0, 0, 4'b1000, 1, 1, 0);

        // PINGPONG bounce at both ends
        step("pp1", 0, 1, 4'b0001, 0, 0, 1);
        step("pp2", 0, 1, 4'b0010, 0, 0, 1);
        step("pp3", 0, 1, 4'b0100, 0, 0, 1);
        step("pp4", 0, 1, 4'b1000, 0, 0, 1);
        step("pp5", 0, 1, 4'b0100, 1, 1, 1);
        step("pp6", 0, 1, 4'b0010, 0, 1, 1);
        step("pp7", 0, 1, 4'b0001, 0, 1, 1);
        step("pp8", 0, 1, 4'b0010, 1, 0, 1);
        step("pp9", 0, 1, 4'b0100, 0, 0, 1);
        step("pp10", 0, 1, 4'b1000, 0, 0, 1);
        // reverse held on the bounce step: still a single flip
        step("pp11", 1, 1, 4'b0100, 1, 1, 1);

        // MIRROR forward then reverse
        step("mi1", 0, 2, 4'b0000, 0, 0, 2);
        step("mi2", 0, 2, 4'b1001, 0, 0, 2);
        step("mi3", 0, 2, 4'b0110, 0, 0, 2);
        step("mi4", 0, 2, 4'b0000, 1, 0, 2);
        step("mi5", 1, 2, 4'b1001, 0, 1, 2);
        step("mi6", 0, 2, 4'b0000, 1, 1, 2);
        step("mi7", 0, 2, 4'b0110, 0, 1, 2);
        step("mi8", 0, 2, 4'b1001, 0, 1, 2);
        step("mi9", 0, 2, 4'b0000, 1, 1, 2);
        step("mi10", 0, 2, 4'b0110, 0, 1, 2);

        // Async reset between edges at 0110
        #3;
        i_reset = 1'b1;
        #1;
        check_all("areset", 4'b0000, 1'b0, 1'b0, 2'd0);
        @(negedge clock);
        i_reset = 1'b0;
        // i_mode equals reset mode; the pending load still reseeds
        step("rl1", 0, 0, 4'b0001, 0, 0, 0);
        step("rl2", 0, 0, 4'b0010, 0, 0, 0);

        // FLASH, direction toggles but pattern unaffected
        step("fl1", 0, 3, 4'b0000, 0, 0, 3);
        step("fl2", 0, 3, 4'b1111, 0, 0, 3);
        step("fl3", 0, 3, 4'b0000, 1, 0, 3);
        step("fl4", 1, 3, 4'b1111, 0, 1, 3);
        step("fl5", 0, 3, 4'b0000, 1, 1, 3);

        // Idle: mode change and reverse ignored, wrap drops
        i_valid   = 1'b0;
        i_reverse = 1'b1;
        i_mode    = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        check_all("idle", 4'b0000, 1'b0, 1'b1, 2'd3);
        step("sw1", 0, 0, 4'b0001, 0, 0, 0);
        step("sw2", 0, 0, 4'b0010, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Parametrised LED pattern sequencer: the next generation of the fixed 4-LED mirror shifter. It generalises LED width and adds four selectable modes: rotate, ping-pong, mirror and flash. It also adds run-time mode switching, an exported direction and a cycle-complete pulse. It sits between the step-rate counter (driving `i_valid`) and the board LED pins.

## Interface
- `NB_LEDS`, 4: number of LEDs; legal ≥ 2.
- `NB_MODE`, 2: mode select width; fixed at 2.
- `clock` in 1: sole clock, rising edge.
- `i_reset` in 1: reset, asynchronous and active-high.
- `i_valid` in 1: step enable; one pattern step per cycle sampled high.
- `i_reverse` in 1: direction toggle, honoured only with `i_valid`.
- `i_mode` in `NB_MODE`: requested mode.
- `o_led` out `NB_LEDS`: registered LED pattern.
- `o_dir` out 1: current direction; 0 = toward MSB / outer-in.
- `o_mode` out `NB_MODE`: mode currently running.
- `o_wrap` out 1: one-cycle pulse when a step completes a pattern cycle.

## Operation
- **State:**
  - `mode_q`
  - `dir_q`
  - `idx_q`, width `$clog2(NB_LEDS+1)`
  - `phase_q`, for flash
  - `load_pend_q`
  - `o_led`
  - `o_wrap`
- **Reset (async):**
  - `o_led` = 0, `o_dir` = 0, `o_mode` = 0, `o_wrap` = 0.
  - `idx_q` = 0, `phase_q` = 0, `load_pend_q` = 1.
- **Load step:** taken when `i_valid` && (`load_pend_q` || `i_mode` != `mode_q`).
  - `mode_q` ← `i_mode`, `dir_q` ← 0, `load_pend_q` ← 0, `o_wrap` ← 0.
  - `i_reverse` is ignored.
  - Seed:
    - SHIFT and PINGPONG: `o_led` = bit0 set, `idx` = 0.
    - MIRROR: all-off, `idx` = 0.
    - FLASH: all-zero, `phase` = 0.
- **Normal step:** taken when `i_valid` and no load.
  - Advance using the current `dir_q`.
  - If `i_reverse`, `dir_q` ← ~`dir_q`; the toggle takes effect on the next step.
- **SHIFT:** one-hot rotate.
  - dir 0: `idx`+1; MSB wraps to bit0 and pulses `o_wrap`.
  - dir 1: `idx`−1; bit0 wraps to MSB and pulses `o_wrap`.
- **PINGPONG:** one-hot bounce.
  - At `idx` = `NB_LEDS`−1 with dir 0, the step moves to `NB_LEDS`−2, forces `dir_q` ← 1 and pulses `o_wrap`.
  - Mirror behaviour at `idx` 0 with dir 1.
  - At an endpoint, the forced direction overrides `i_reverse`; the net result is a single flip.
- **MIRROR:** states are OFF, then pairs P0..P(K−1), with K = ceil(`NB_LEDS`/2).
  - Pk lights bits k and `NB_LEDS`−1−k.
  - dir 0: OFF→P0→…→P(K−1)→OFF.
  - dir 1: OFF→P(K−1)→…→P0→OFF.
  - Entering OFF from a pair pulses `o_wrap`.
- **FLASH:** alternates all-ones and all-zeros.
  - Direction has no effect on the pattern; `dir_q` still toggles on `i_reverse`.
  - The 1→0 transition pulses `o_wrap`.
- **Idle:** with `i_valid` = 0, all state holds, `o_wrap` = 0, and `i_reverse` / `i_mode` are ignored.

## Timing
- All outputs are registered.
- `o_led`, `o_dir` and `o_mode` update on the edge that samples `i_valid` = 1; latency 1 cycle.
- `o_wrap` is high exactly the one cycle following the completing step. It is low otherwise, including on back-to-back non-completing steps.
- A mode change is never mid-step: it is applied only on a valid cycle, as a load step that does not advance the pattern.
- Reset asserted mid-sequence clears outputs immediately (asynchronous). The first valid after deassert is a load step.
- Back-to-back valid cycles are legal: one step per cycle, with no bubbles.

## Structure
- Package `led_seq_pkg` holds:
  - mode encodings: `MODE_SHIFT`=0, `MODE_PINGPONG`=1, `MODE_MIRROR`=2, `MODE_FLASH`=3
  - `DIR_FWD`=0, `DIR_REV`=1
- Sub-module `led_pattern_decode` is combinational: `mode`, `idx`, `phase` → `NB_LEDS`-bit pattern (one-hot, pair or flash).
- The top module holds the state/step FSM and the output registers.

## Test plan
All scenarios use `NB_LEDS`=4.
- **SHIFT rotate:** reset, `i_mode`=0, 6 valid pulses → `o_led` 0001, 0010, 0100, 1000, 0001, 0010; `o_wrap` high only after the 5th.
- **SHIFT reverse:** at 0100, valid with `i_reverse` → 1000 with `o_dir`=1. Next valid → 0100, then 0010.
- **PINGPONG bounce:** 6 valids → 0001, 0010, 0100, 1000, 0100, 0010; `o_wrap` after the 5th; `o_dir`=1 after the 5th. Repeat with `i_reverse` held at the bounce step → `o_dir` still 1.
- **MIRROR both directions:**
  - 4 valids → 0000, 1001, 0110, 0000, with `o_wrap` after the 4th.
  - Then valid+`i_reverse` → 1001. Next → 0110? No: dir 1 from 1001 → 0000 with `o_wrap`; check against K=2 ordering 0110→1001→0000.
- **Mode switch and idle:** in FLASH (0000, 1111, 0000), change `i_mode` to SHIFT with `i_valid`=0 → no change. Next valid → 0001, `o_mode`=0, `o_dir`=0.
- **Async reset mid-run:** assert `i_reset` between edges at 0110 → `o_led`=0000 before the next edge. After release, the first valid loads the seed of `i_mode`.
